// File: rtl/uart_rx_fifo_if.sv
// Host-side pop/status interface of the UART receiver FIFO.
// The receiver drives the slave side; the host consumer uses the master side.
interface uart_rx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_WIDTH = 4
);
    logic                  Pop_Data;
    logic                  Clr_Overflow;
    logic [DATA_BITS-1:0]  Data_Out;
    logic [2:0]            Rx_Error;
    logic                  Data_Rdy;
    logic                  FIFO_Empty;
    logic                  FIFO_Full;
    logic                  FIFO_Overflow;
    logic [FIFO_WIDTH:0]   FIFO_Count;
    logic                  RTS;
    logic                  Rx_Busy;

    modport slave (
        input  Pop_Data, Clr_Overflow,
        output Data_Out, Rx_Error, Data_Rdy, FIFO_Empty, FIFO_Full,
               FIFO_Overflow, FIFO_Count, RTS, Rx_Busy
    );

    modport master (
        output Pop_Data, Clr_Overflow,
        input  Data_Out, Rx_Error, Data_Rdy, FIFO_Empty, FIFO_Full,
               FIFO_Overflow, FIFO_Count, RTS, Rx_Busy
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with parity/frame/break detection, a
// first-word-fall-through receive FIFO and threshold-driven RTS.
module uart_rx_fifo #(
    parameter int CLK_RATE      = 100000000,
    parameter int BAUD_RATE     = 9600,
    parameter int OVERSAMPLE    = 16,
    parameter int DATA_BITS     = 8,
    parameter int STOP_BITS     = 2,
    parameter int FIFO_WIDTH    = 4,
    parameter int RTS_THRESHOLD = 12
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          Rx,
    input  logic [1:0]    Parity_Mode,
    uart_rx_fifo_if.slave host
);
    localparam int DIV_RAW = CLK_RATE / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = $clog2(DIV + 1);
    localparam int SAMP_W  = $clog2(OVERSAMPLE);
    localparam int DEPTH   = 1 << FIFO_WIDTH;
    localparam int ENTRY_W = DATA_BITS + 3;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

    state_t                 state_q;
    logic [DIV_W-1:0]       div_q;
    logic [SAMP_W-1:0]      samp_q;
    logic [3:0]             bit_q;
    logic [DATA_BITS-1:0]   shreg_q;
    logic [1:0]             mode_q;
    logic                   brk_q, frame_q, par_err_q;
    logic                   rx_meta_q, rx_sync_q, rx_prev_q;
    logic                   busy_q, push_q, rts_q, ovf_q;
    logic [ENTRY_W-1:0]     push_entry_q;
    logic [ENTRY_W-1:0]     mem_q [DEPTH];
    logic [FIFO_WIDTH-1:0]  wr_ptr_q, rd_ptr_q;
    logic [FIFO_WIDTH:0]    count_q, count_d;
    logic                   tick_s, par_en_s, stop_brk_s, stop_frm_s;
    logic                   empty_s, full_s, pop_s, push_ok_s, ovf_set_s;
    logic [ENTRY_W-1:0]     stop_entry_s, head_s;

    // Two-flop synchroniser plus one history flop for falling-edge detection.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= Rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Free-running oversample tick divider.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            div_q <= '0;
        end else if (div_q == DIV_W'(DIV - 1)) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // Break needs the first stop bit low too; with one stop bit that is the last sample.
    always_comb begin
        tick_s     = (div_q == DIV_W'(DIV - 1));
        par_en_s   = (mode_q == 2'b01) || (mode_q == 2'b10);
        stop_frm_s = frame_q | ~rx_sync_q;
        if (bit_q == 4'd0) begin
            stop_brk_s = brk_q & ~rx_sync_q;
        end else begin
            stop_brk_s = brk_q;
        end
        if (stop_brk_s) begin
            stop_entry_s = {3'b001, {DATA_BITS{1'b0}}};
        end else begin
            stop_entry_s = {stop_frm_s, par_err_q, 1'b0, shreg_q};
        end
    end

    // Deframing FSM; Rx_Busy and the push strobe are registered here.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q      <= S_IDLE;
            samp_q       <= '0;
            bit_q        <= 4'd0;
            shreg_q      <= '0;
            mode_q       <= 2'b00;
            brk_q        <= 1'b0;
            frame_q      <= 1'b0;
            par_err_q    <= 1'b0;
            busy_q       <= 1'b0;
            push_q       <= 1'b0;
            push_entry_q <= '0;
        end else begin
            push_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        state_q <= S_START;
                        samp_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    if (tick_s) begin
                        if (samp_q == SAMP_W'(OVERSAMPLE / 2 - 1)) begin
                            samp_q <= '0;
                            if (rx_sync_q) begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q   <= S_DATA;
                                mode_q    <= Parity_Mode;
                                bit_q     <= 4'd0;
                                brk_q     <= 1'b1;
                                frame_q   <= 1'b0;
                                par_err_q <= 1'b0;
                            end
                        end else begin
                            samp_q <= samp_q + SAMP_W'(1);
                        end
                    end
                end
                S_DATA: begin
                    if (tick_s) begin
                        if (samp_q == SAMP_W'(OVERSAMPLE - 1)) begin
                            samp_q  <= '0;
                            shreg_q <= {rx_sync_q, shreg_q[DATA_BITS-1:1]};
                            brk_q   <= brk_q & ~rx_sync_q;
                            if (bit_q == 4'(DATA_BITS - 1)) begin
                                bit_q   <= 4'd0;
                                state_q <= par_en_s ? S_PARITY : S_STOP;
                            end else begin
                                bit_q <= bit_q + 4'd1;
                            end
                        end else begin
                            samp_q <= samp_q + SAMP_W'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (tick_s) begin
                        if (samp_q == SAMP_W'(OVERSAMPLE - 1)) begin
                            samp_q  <= '0;
                            brk_q   <= brk_q & ~rx_sync_q;
                            state_q <= S_STOP;
                            bit_q   <= 4'd0;
                            if (mode_q == 2'b01) begin
                                par_err_q <= calc_parity(shreg_q) ^ rx_sync_q;
                            end else begin
                                par_err_q <= ~(calc_parity(shreg_q) ^ rx_sync_q);
                            end
                        end else begin
                            samp_q <= samp_q + SAMP_W'(1);
                        end
                    end
                end
                S_STOP: begin
                    if (tick_s) begin
                        if (samp_q == SAMP_W'(OVERSAMPLE - 1)) begin
                            samp_q <= '0;
                            if (bit_q == 4'(STOP_BITS - 1)) begin
                                state_q      <= S_IDLE;
                                busy_q       <= 1'b0;
                                push_q       <= 1'b1;
                                push_entry_q <= stop_entry_s;
                            end else begin
                                frame_q <= stop_frm_s;
                                brk_q   <= stop_brk_s;
                                bit_q   <= bit_q + 4'd1;
                            end
                        end else begin
                            samp_q <= samp_q + SAMP_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // A push into a full FIFO only succeeds when a pop frees a slot in the same cycle.
    always_comb begin
        empty_s   = (count_q == '0);
        full_s    = (count_q == (FIFO_WIDTH+1)'(DEPTH));
        pop_s     = host.Pop_Data && !empty_s;
        push_ok_s = push_q && (!full_s || pop_s);
        ovf_set_s = push_q && full_s && !pop_s;
        head_s    = mem_q[rd_ptr_q];
        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + (FIFO_WIDTH+1)'(1);
            2'b01:   count_d = count_q - (FIFO_WIDTH+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage array.
    always_ff @(posedge Clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_entry_q;
        end
    end

    // FIFO pointers, count, sticky overflow and registered RTS.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            rts_q    <= 1'b1;
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + FIFO_WIDTH'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + FIFO_WIDTH'(1);
            end
            count_q <= count_d;
            if (ovf_set_s) begin
                ovf_q <= 1'b1;
            end else if (host.Clr_Overflow) begin
                ovf_q <= 1'b0;
            end
            rts_q <= (count_q < (FIFO_WIDTH+1)'(RTS_THRESHOLD));
        end
    end

    assign host.Data_Out      = empty_s ? '0 : head_s[DATA_BITS-1:0];
    assign host.Rx_Error      = empty_s ? 3'b000 : head_s[ENTRY_W-1:DATA_BITS];
    assign host.Data_Rdy      = !empty_s;
    assign host.FIFO_Empty    = empty_s;
    assign host.FIFO_Full     = full_s;
    assign host.FIFO_Overflow = ovf_q;
    assign host.FIFO_Count    = count_q;
    assign host.RTS           = rts_q;
    assign host.Rx_Busy       = busy_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: expected entries go into a scoreboard
// queue, and a negedge monitor checks the head on every accepted pop.
module tb_uart_rx_fifo;
    localparam int OS      = 16;
    localparam int DIV     = 2;
    localparam int BIT_CYC = OS * DIV;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       Rx = 1'b1;
    logic [1:0] Parity_Mode = 2'b00;

    int total = 0;
    int bad   = 0;
    logic [10:0] exp_q [$];

    uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_WIDTH(4)) host_if ();

    uart_rx_fifo #(
        .CLK_RATE(3200000), .BAUD_RATE(100000), .OVERSAMPLE(OS),
        .DATA_BITS(8), .STOP_BITS(2), .FIFO_WIDTH(4), .RTS_THRESHOLD(12)
    ) dut (
        .Clk(Clk), .Rst(Rst), .Rx(Rx), .Parity_Mode(Parity_Mode), .host(host_if)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted pop must show the oldest expected entry.
    always @(negedge Clk) begin
        if (Rst && host_if.Pop_Data && host_if.Data_Rdy) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_unexpected: got %0h expected none",
                         {host_if.Rx_Error, host_if.Data_Out});
            end else begin
                chk("pop_entry", {21'd0, host_if.Rx_Error, host_if.Data_Out},
                    {21'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic hold(input logic v, input int n);
        Rx = v;
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic has_par, input logic pbit,
                              input logic s0, input logic s1, input logic [1:0] mode_after);
        hold(1'b0, BIT_CYC);
        Parity_Mode = mode_after;
        for (int i = 0; i < 8; i++) hold(d[i], BIT_CYC);
        if (has_par) hold(pbit, BIT_CYC);
        hold(s0, BIT_CYC);
        hold(s1, BIT_CYC);
        hold(1'b1, 2 * BIT_CYC);
    endtask

    task automatic pop_one();
        @(posedge Clk); #1;
        host_if.Pop_Data = 1'b1;
        @(posedge Clk); #1;
        host_if.Pop_Data = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (host_if.Data_Rdy && guard < 40) begin
            pop_one();
            guard++;
        end
        @(negedge Clk);
        chk("drain_empty", {31'd0, host_if.FIFO_Empty}, 32'd1);
        chk("drain_sb_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        host_if.Pop_Data     = 1'b0;
        host_if.Clr_Overflow = 1'b0;
        repeat (3) @(negedge Clk);
        chk("rst_data",  {24'd0, host_if.Data_Out}, 32'd0);
        chk("rst_err",   {29'd0, host_if.Rx_Error}, 32'd0);
        chk("rst_rdy",   {31'd0, host_if.Data_Rdy}, 32'd0);
        chk("rst_empty", {31'd0, host_if.FIFO_Empty}, 32'd1);
        chk("rst_full",  {31'd0, host_if.FIFO_Full}, 32'd0);
        chk("rst_ovf",   {31'd0, host_if.FIFO_Overflow}, 32'd0);
        chk("rst_count", {27'd0, host_if.FIFO_Count}, 32'd0);
        chk("rst_rts",   {31'd0, host_if.RTS}, 32'd1);
        chk("rst_busy",  {31'd0, host_if.Rx_Busy}, 32'd0);
        @(posedge Clk); #1;
        Rst = 1'b1;
        hold(1'b1, 4);

        // Even parity, clean frame.
        Parity_Mode = 2'b01;
        exp_q.push_back({3'b000, 8'hA5});
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01);
        @(negedge Clk);
        chk("t1_count", {27'd0, host_if.FIFO_Count}, 32'd1);
        chk("t1_data",  {24'd0, host_if.Data_Out}, 32'hA5);
        chk("t1_err",   {29'd0, host_if.Rx_Error}, 32'd0);
        pop_one();
        @(negedge Clk);
        chk("t1_empty", {31'd0, host_if.FIFO_Empty}, 32'd1);
        chk("t1_data0", {24'd0, host_if.Data_Out}, 32'd0);

        // Odd parity error, then no-parity frame with mode changed mid-frame.
        Parity_Mode = 2'b10;
        exp_q.push_back({3'b010, 8'h3C});
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10);
        Parity_Mode = 2'b00;
        exp_q.push_back({3'b000, 8'h3C});
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01);
        @(negedge Clk);
        chk("t2_count", {27'd0, host_if.FIFO_Count}, 32'd2);
        chk("t2_err",   {29'd0, host_if.Rx_Error}, 32'd2);
        drain();

        // Frame error: both stop bits low.
        Parity_Mode = 2'b01;
        exp_q.push_back({3'b100, 8'h55});
        send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01);
        @(negedge Clk);
        chk("t3_err", {29'd0, host_if.Rx_Error}, 32'd4);
        drain();

        // Break, then a valid frame.
        exp_q.push_back({3'b001, 8'h00});
        hold(1'b0, 20 * BIT_CYC);
        hold(1'b1, 2 * BIT_CYC);
        @(negedge Clk);
        chk("t4_count1", {27'd0, host_if.FIFO_Count}, 32'd1);
        exp_q.push_back({3'b000, 8'h81});
        send_frame(8'h81, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01);
        @(negedge Clk);
        chk("t4_count2", {27'd0, host_if.FIFO_Count}, 32'd2);
        chk("t4_err",    {29'd0, host_if.Rx_Error}, 32'd1);
        drain();

        // False start glitch.
        hold(1'b0, OS / 4 * DIV);
        @(negedge Clk);
        chk("t5_busy_hi", {31'd0, host_if.Rx_Busy}, 32'd1);
        hold(1'b1, 40);
        @(negedge Clk);
        chk("t5_busy_lo", {31'd0, host_if.Rx_Busy}, 32'd0);
        chk("t5_count",   {27'd0, host_if.FIFO_Count}, 32'd0);

        // Fill, RTS threshold, full, overflow.
        Parity_Mode = 2'b00;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) exp_q.push_back({3'b000, 8'(i)});
            send_frame(8'(i), 1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
            @(negedge Clk);
            if (i == 10) chk("t6_rts_11", {31'd0, host_if.RTS}, 32'd1);
            if (i == 11) chk("t6_rts_12", {31'd0, host_if.RTS}, 32'd0);
            if (i == 14) chk("t6_full_15", {31'd0, host_if.FIFO_Full}, 32'd0);
            if (i == 15) begin
                chk("t6_full_16", {31'd0, host_if.FIFO_Full}, 32'd1);
                chk("t6_ovf_16",  {31'd0, host_if.FIFO_Overflow}, 32'd0);
            end
        end
        chk("t6_ovf_17",   {31'd0, host_if.FIFO_Overflow}, 32'd1);
        chk("t6_count_17", {27'd0, host_if.FIFO_Count}, 32'd16);
        chk("t6_head_17",  {24'd0, host_if.Data_Out}, 32'd0);

        exp_q.push_back({3'b000, 8'h11});
        fork
            send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
            begin
                repeat (5 * BIT_CYC) @(posedge Clk);
                pop_one();
            end
        join
        @(negedge Clk);
        chk("t6_count_18", {27'd0, host_if.FIFO_Count}, 32'd16);
        chk("t6_full_18",  {31'd0, host_if.FIFO_Full}, 32'd1);
        chk("t6_head_18",  {24'd0, host_if.Data_Out}, 32'd1);
        @(posedge Clk); #1;
        host_if.Clr_Overflow = 1'b1;
        @(posedge Clk); #1;
        host_if.Clr_Overflow = 1'b0;
        @(negedge Clk);
        chk("t6_ovf_clr", {31'd0, host_if.FIFO_Overflow}, 32'd0);
        drain();
        @(negedge Clk);
        chk("t6_rts_back", {31'd0, host_if.RTS}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised next-generation UART receiver with an integrated receive FIFO.
- Oversamples the serial Rx line and deframes packets with configurable data bits, stop bits and a runtime-selectable parity mode.
- Detects parity, frame and break errors and stores them in the FIFO alongside each data word.
- Drives RTS flow control from a programmable FIFO fill threshold.
- Sits between the Rx pin and the host-side pop interface.

Parameters:
CLK_RATE, 100000000, Clk frequency in Hz.
BAUD_RATE, 9600, line rate in baud.
OVERSAMPLE, 16, sample ticks per bit; even, 8..32.
DATA_BITS, 8, data bits per frame; 5..9.
STOP_BITS, 2, stop bits per frame; 1..2.
FIFO_WIDTH, 4, FIFO address width; depth = 2**FIFO_WIDTH.
RTS_THRESHOLD, 12, fill level at which RTS deasserts; 1..depth.

Ports:
Clk  in  1  system clock; all state is on posedge Clk.
Rst  in  1  asynchronous, active-low reset.
Rx  in  1  serial input; idle high.
Parity_Mode  in  2  00 none, 01 even, 10 odd, 11 none.
Pop_Data  in  1  removes the head FIFO entry.
Clr_Overflow  in  1  clears sticky FIFO_Overflow.
Data_Out  out  DATA_BITS  head entry data.
Rx_Error  out  3  head entry errors: [0] break, [1] parity, [2] frame.
Data_Rdy  out  1  FIFO not empty.
FIFO_Empty  out  1  count == 0.
FIFO_Full  out  1  count == depth.
FIFO_Overflow  out  1  sticky; set when a frame arrives while the FIFO is full.
FIFO_Count  out  FIFO_WIDTH+1  number of stored entries.
RTS  out  1  1 = ready to receive.
Rx_Busy  out  1  high while a frame is in progress.

Behaviour:
- Reset (Rst=0, async): FSM goes to IDLE. FIFO pointers and count are cleared. Rx synchroniser flops are set to 1.
  - Outputs: Data_Out=0, Rx_Error=0, Data_Rdy=0, FIFO_Empty=1, FIFO_Full=0, FIFO_Overflow=0, FIFO_Count=0, RTS=1, Rx_Busy=0.
  - A partial frame in progress is discarded.
- Tick generator:
  - DIV = max(1, CLK_RATE / (BAUD_RATE*OVERSAMPLE)), integer floor.
  - Free-running counter 0..DIV-1; one-cycle tick when it wraps.
- Rx passes through a 2-flop synchroniser; start detection uses its output.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on a synchronised falling edge (previous 1, current 0), clear the sample counter and go to START. Rx_Busy=1 from this cycle on.
  - START: at tick count OVERSAMPLE/2 (mid-bit), Rx=1 means a false start: return to IDLE and drop Rx_Busy. Rx=0 latches Parity_Mode and goes to DATA. Parity_Mode changes after this point do not affect the current frame.
  - DATA: sample every OVERSAMPLE ticks. Data is LSB first; shift DATA_BITS bits. Then go to PARITY if the latched mode is even or odd, otherwise to STOP.
  - PARITY: sample one bit.
    - Even: error if XOR(data, bit) = 1.
    - Odd: error if XOR(data, bit) = 0.
  - STOP: sample STOP_BITS bits. Any 0 sets frame. After the mid-bit sample of the last stop bit, push the entry on the next cycle and go to IDLE with Rx_Busy=0.
- Break: all data bits, the parity bit (if present) and the first stop bit sampled 0.
  - Entry gets Rx_Error=001, data 0; parity and frame bits are forced 0.
  - The edge-detecting IDLE guarantees no new frame starts until Rx returns high.
- FIFO storage:
  - Each entry is {Rx_Error, data}. Data_Out and Rx_Error show the head combinationally (first-word-fall-through), and read 0 when empty.
  - Pop_Data while empty is ignored.
  - Push while full with no simultaneous pop: entry dropped, FIFO_Overflow set on the next cycle. It stays set until Clr_Overflow=1 or reset.
  - Push and pop in the same cycle, full or not: both are accepted and the count is unchanged.
  - Pointers wrap modulo depth.
- RTS is registered:
  - Goes 0 the cycle after the count becomes >= RTS_THRESHOLD.
  - Goes 1 the cycle after the count drops below RTS_THRESHOLD.
  - RTS does not gate reception; frames still arrive and may overflow.

Test Plan:
1. Parity_Mode=01, send 0xA5 with parity 0 and two stop bits -> FIFO_Count=1, Data_Out=A5, Rx_Error=000 one cycle after the last stop mid-sample; Pop_Data -> FIFO_Empty=1, Data_Out=0.
2. Parity_Mode=10, send 0x3C with parity bit 0 -> Data_Out=3C, Rx_Error=010. Then Parity_Mode=00, send 0x3C with no parity bit -> second entry Rx_Error=000.
3. Parity_Mode=01, send 0x55 with both stop bits 0, then Rx high -> Data_Out=55, Rx_Error=100.
4. Hold Rx low for 20 bit times, then high -> exactly one entry, Data_Out=00, Rx_Error=001; a following valid 0x81 frame gives a second entry 81/000.
5. Glitch Rx low for OVERSAMPLE/4 ticks -> Rx_Busy pulses and returns 0 at mid-start; FIFO_Count stays 0.
6. With defaults, send 17 frames 0x00..0x10 without popping:
   - RTS=0 one cycle after the 12th push; FIFO_Full=1 after the 16th.
   - The 17th frame is dropped and FIFO_Overflow=1; head still 00.
   - Pop once while frame 18 completes -> count stays 16, no new overflow.
   - Clr_Overflow -> FIFO_Overflow=0.
